// File: rtl/antic_dlist_dma_pkg.sv
// Shared types and helpers for the ANTIC display-list DMA engine:
// FSM encoding, DMACTL field positions and mode-line length rules.
package antic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    IR_REQ,
    IR_CAP,
    OPL_REQ,
    OPL_CAP,
    OPH_REQ,
    OPH_CAP,
    DATA_REQ,
    DATA_CAP,
    WAITVB,
    DONE
  } state_t;

  localparam int DMACTL_PFW_LO = 0;
  localparam int DMACTL_PFW_HI = 1;
  localparam int DMACTL_DL_EN  = 5;
  localparam int PFW_W = DMACTL_PFW_HI - DMACTL_PFW_LO + 1;

  localparam logic [5:0] PF_BYTES_NONE   = 6'd0;
  localparam logic [5:0] PF_BYTES_NARROW = 6'd32;
  localparam logic [5:0] PF_BYTES_NORMAL = 6'd40;
  localparam logic [5:0] PF_BYTES_WIDE   = 6'd48;

  // Divisor expressed as a shift: 1, 2 or 4 bytes-per-position.
  function automatic logic [1:0] mode_div_log2(input logic [3:0] mode);
    logic [1:0] sh;
    unique case (1'b1)
      (mode == 4'h8 || mode == 4'h9): sh = 2'd2;
      (mode inside {4'h6, 4'h7, 4'hA, 4'hB, 4'hC}): sh = 2'd1;
      default: sh = 2'd0;
    endcase
    return sh;
  endfunction

  function automatic logic [5:0] line_len(
    input logic [PFW_W-1:0] pfw,
    input logic [3:0]       mode
  );
    logic [5:0] w;
    unique case (pfw)
      2'b00:   w = PF_BYTES_NONE;
      2'b01:   w = PF_BYTES_NARROW;
      2'b10:   w = PF_BYTES_NORMAL;
      default: w = PF_BYTES_WIDE;
    endcase
    return w >> mode_div_log2(mode);
  endfunction

endpackage

// File: rtl/antic_dlist_dma_if.sv
// System-bus and line-buffer signals of the display-list DMA engine.
// The engine is the master; memory and the line buffer are the slave.
interface antic_dlist_dma_if #(
  parameter int ADDR_W = 16,
  parameter int BUF_AW = 6
);
  logic              halt_L;
  logic [ADDR_W-1:0] address;
  logic [7:0]        DB;
  logic              buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [7:0]        buf_data;

  modport master (
    output halt_L,
    output address,
    input  DB,
    output buf_we,
    output buf_addr,
    output buf_data
  );

  modport slave (
    input  halt_L,
    input  address,
    output DB,
    input  buf_we,
    input  buf_addr,
    input  buf_data
  );
endinterface

// File: rtl/antic_dlist_dma_wrap_inc.sv
// Masked increment: only the low WRAP_BITS count, the
// upper bits of the counter stay fixed (ANTIC page wrap).
module antic_wrap_inc #(
  parameter int ADDR_W    = 16,
  parameter int WRAP_BITS = 10
) (
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] y
);
  logic [WRAP_BITS-1:0] lo;

  assign lo = a[WRAP_BITS-1:0] + WRAP_BITS'(1);
  assign y  = {a[ADDR_W-1:WRAP_BITS], lo};
endmodule

// File: rtl/antic_dlist_dma.sv
// Display-list DMA: fetches IR, operands and playfield bytes
// for one mode line per request, two cycles per byte.
module antic_dlist_dma
  import antic_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DL_WRAP_BITS  = 10,
  parameter int MSR_WRAP_BITS = 12,
  parameter int BUF_AW        = 6
) (
  input  logic              phi2,
  input  logic              rst_L,
  input  logic              dma_en,
  input  logic [PFW_W-1:0]  pf_width,
  input  logic              dlist_load,
  input  logic [ADDR_W-1:0] dlist_init,
  input  logic              mode_req,
  input  logic              vblank,
  antic_dlist_dma_if.master bus,
  output logic [ADDR_W-1:0] dlist_ptr,
  output logic [ADDR_W-1:0] msr,
  output logic [7:0]        IR,
  output logic              busy,
  output logic              wait_vb,
  output logic              line_done,
  output logic [5:0]        line_bytes
);

  state_t            state;
  logic              halt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] msr_q;
  logic [7:0]        ir_q;
  logic              busy_q;
  logic              wvb_q;
  logic              we_q;
  logic [BUF_AW-1:0] baddr_q;
  logic              done_q;
  logic [5:0]        cnt_q;
  logic [5:0]        n_q;
  logic [7:0]        op_lo;
  logic              jvb_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_ptr;

  logic [ADDR_W-1:0] dl_inc;
  logic [ADDR_W-1:0] msr_inc;
  logic [ADDR_W-1:0] target;
  logic [3:0]        db_mode;
  logic              has_ops;
  logic [5:0]        n_new;
  logic [5:0]        cnt_inc;

  antic_wrap_inc #(
    .ADDR_W   (ADDR_W),
    .WRAP_BITS(DL_WRAP_BITS)
  ) u_dl_inc (
    .a(ptr_q),
    .y(dl_inc)
  );

  antic_wrap_inc #(
    .ADDR_W   (ADDR_W),
    .WRAP_BITS(MSR_WRAP_BITS)
  ) u_msr_inc (
    .a(msr_q),
    .y(msr_inc)
  );

  assign db_mode = bus.DB[3:0];
  assign has_ops = (db_mode == 4'h1) ||
                   (bus.DB[6] && db_mode >= 4'h2);
  assign n_new   = line_len(pf_width, db_mode);
  assign target  = ADDR_W'({bus.DB, op_lo});
  assign cnt_inc = cnt_q + 6'd1;

  always_ff @(posedge phi2 or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      halt_q   <= 1'b1;
      addr_q   <= '0;
      ptr_q    <= '0;
      msr_q    <= '0;
      ir_q     <= '0;
      busy_q   <= 1'b0;
      wvb_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      op_lo    <= '0;
      jvb_q    <= 1'b0;
      pend_q   <= 1'b0;
      pend_ptr <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      // A CPU write mid-line is held until the line retires.
      if (dlist_load && busy_q && state != WAITVB
          && state != DONE) begin
        pend_q   <= 1'b1;
        pend_ptr <= dlist_init;
      end
      unique case (state)
        IDLE: begin
          if (dlist_load) ptr_q <= dlist_init;
          if (mode_req) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (dma_en) begin
              state  <= IR_REQ;
              halt_q <= 1'b0;
              addr_q <= dlist_load ? dlist_init : ptr_q;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              ir_q   <= '0;
            end
          end
        end
        IR_REQ: begin
          state  <= IR_CAP;
          halt_q <= 1'b1;
        end
        IR_CAP: begin
          ir_q  <= bus.DB;
          ptr_q <= dl_inc;
          n_q   <= n_new;
          if (has_ops) begin
            state  <= OPL_REQ;
            halt_q <= 1'b0;
            addr_q <= dl_inc;
          end else if (db_mode == 4'h0 || n_new == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state  <= DATA_REQ;
            halt_q <= 1'b0;
            addr_q <= msr_q;
          end
        end
        OPL_REQ: begin
          state  <= OPL_CAP;
          halt_q <= 1'b1;
        end
        OPL_CAP: begin
          op_lo  <= bus.DB;
          ptr_q  <= dl_inc;
          state  <= OPH_REQ;
          halt_q <= 1'b0;
          addr_q <= dl_inc;
        end
        OPH_REQ: begin
          state  <= OPH_CAP;
          halt_q <= 1'b1;
        end
        OPH_CAP: begin
          if (ir_q[3:0] == 4'h1) begin
            ptr_q  <= target;
            jvb_q  <= ir_q[6];
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            ptr_q <= dl_inc;
            msr_q <= target;
            if (n_q == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= DATA_REQ;
              halt_q <= 1'b0;
              addr_q <= target;
            end
          end
        end
        DATA_REQ: begin
          state   <= DATA_CAP;
          halt_q  <= 1'b1;
          we_q    <= 1'b1;
          baddr_q <= BUF_AW'(cnt_q);
        end
        DATA_CAP: begin
          msr_q <= msr_inc;
          cnt_q <= cnt_inc;
          if (cnt_inc == n_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state  <= DATA_REQ;
            halt_q <= 1'b0;
            addr_q <= msr_inc;
          end
        end
        WAITVB: begin
          if (dlist_load) ptr_q <= dlist_init;
          if (vblank) begin
            state  <= IDLE;
            wvb_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          if (dlist_load) ptr_q <= dlist_init;
          else if (pend_q) ptr_q <= pend_ptr;
          pend_q <= 1'b0;
          jvb_q  <= 1'b0;
          if (jvb_q) begin
            state <= WAITVB;
            wvb_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          halt_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halt_L   = halt_q;
  assign bus.address  = addr_q;
  assign bus.buf_we   = we_q;
  assign bus.buf_addr = baddr_q;
  assign bus.buf_data = we_q ? bus.DB : 8'h00;

  assign dlist_ptr  = ptr_q;
  assign msr        = msr_q;
  assign IR         = ir_q;
  assign busy       = busy_q;
  assign wait_vb    = wvb_q;
  assign line_done  = done_q;
  assign line_bytes = cnt_q;

endmodule

// File: tb/tb_antic_dlist_dma.sv
// Bench for antic_dlist_dma: directed table, corner sequences
// and random mode lines against a transaction-level model.
module tb_antic_dlist_dma;

  logic        phi2 = 1'b0;
  logic        rst_L;
  logic        dma_en;
  logic [1:0]  pf_width;
  logic        dlist_load;
  logic [15:0] dlist_init;
  logic        mode_req;
  logic        vblank;
  logic [15:0] dlist_ptr;
  logic [15:0] msr;
  logic [7:0]  IR;
  logic        busy;
  logic        wait_vb;
  logic        line_done;
  logic [5:0]  line_bytes;

  antic_dlist_dma_if #(.ADDR_W(16), .BUF_AW(6)) bus ();

  antic_dlist_dma dut (
    .phi2      (phi2),
    .rst_L     (rst_L),
    .dma_en    (dma_en),
    .pf_width  (pf_width),
    .dlist_load(dlist_load),
    .dlist_init(dlist_init),
    .mode_req  (mode_req),
    .vblank    (vblank),
    .bus       (bus),
    .dlist_ptr (dlist_ptr),
    .msr       (msr),
    .IR        (IR),
    .busy      (busy),
    .wait_vb   (wait_vb),
    .line_done (line_done),
    .line_bytes(line_bytes)
  );

  always #5 phi2 = ~phi2;

  logic [7:0] mem [65536];

  always @(posedge phi2)
    if (!bus.halt_L) bus.DB <= mem[bus.address];

  logic        mon = 1'b0;
  logic [15:0] fetch_q[$];
  logic [13:0] wr_q[$];
  int          ldone_cnt;

  always @(negedge phi2)
    if (mon) begin
      if (!bus.halt_L) fetch_q.push_back(bus.address);
      if (bus.buf_we) wr_q.push_back({bus.buf_addr, bus.buf_data});
      if (line_done) ldone_cnt++;
    end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] wrap_next(input logic [15:0] a,
                                            input int bits);
    logic [15:0] m;
    m = 16'((32'h1 << bits) - 1);
    return (a & ~m) | ((a + 16'd1) & m);
  endfunction

  logic [15:0] mdl_ptr = 16'h0;
  logic [15:0] mdl_msr = 16'h0;
  logic        mdl_jvb;
  logic [5:0]  obs_bytes;
  logic [15:0] obs_ptr;
  logic [15:0] obs_msr;
  int          obs_cyc;

  task automatic run_line(input logic en, input int ld_at,
                          input logic [15:0] ld_val, input string tag);
    logic [15:0] ef[$];
    logic [13:0] ew[$];
    logic [7:0]  eir;
    logic [3:0]  md;
    logic [7:0]  lo, hi;
    int w, dv, n, k, bad;
    eir = 8'h00;
    mdl_jvb = 1'b0;
    if (ld_at == 0) mdl_ptr = ld_val;
    if (en) begin
      eir = mem[mdl_ptr];
      ef.push_back(mdl_ptr);
      mdl_ptr = wrap_next(mdl_ptr, 10);
      md = eir[3:0];
      if (md == 4'h1 || (eir[6] && md >= 4'h2)) begin
        lo = mem[mdl_ptr]; ef.push_back(mdl_ptr);
        mdl_ptr = wrap_next(mdl_ptr, 10);
        hi = mem[mdl_ptr]; ef.push_back(mdl_ptr);
        mdl_ptr = wrap_next(mdl_ptr, 10);
        if (md == 4'h1) begin
          mdl_ptr = {hi, lo};
          mdl_jvb = eir[6];
        end else mdl_msr = {hi, lo};
      end
      if (md >= 4'h2) begin
        w  = (pf_width == 0) ? 0 : (pf_width == 1) ? 32 :
             (pf_width == 2) ? 40 : 48;
        dv = (md == 8 || md == 9) ? 4 :
             (md inside {6, 7, 10, 11, 12}) ? 2 : 1;
        n  = w / dv;
        for (int i = 0; i < n; i++) begin
          ef.push_back(mdl_msr);
          ew.push_back({6'(i), mem[mdl_msr]});
          mdl_msr = wrap_next(mdl_msr, 12);
        end
      end
    end
    if (ld_at > 0) mdl_ptr = ld_val;

    fetch_q.delete();
    wr_q.delete();
    ldone_cnt = 0;
    @(posedge phi2); #1;
    dma_en   = en;
    mode_req = 1'b1;
    mon      = 1'b1;
    if (ld_at == 0) begin
      dlist_load = 1'b1;
      dlist_init = ld_val;
    end
    @(posedge phi2); #1;
    mode_req   = 1'b0;
    dlist_load = 1'b0;
    k = 0;
    while (!line_done && k < 300) begin
      if (ld_at > 0 && k == ld_at) begin
        dlist_load = 1'b1;
        dlist_init = ld_val;
      end
      @(posedge phi2); #1;
      dlist_load = 1'b0;
      k++;
    end
    chk({tag, ".line_done"}, line_done, 1'b1);
    chk({tag, ".cycles"}, k, 2 * ef.size());
    chk({tag, ".line_bytes"}, line_bytes, ew.size());
    chk({tag, ".IR"}, IR, eir);
    obs_cyc   = k;
    obs_bytes = line_bytes;
    @(posedge phi2); #1;
    mon = 1'b0;
    obs_ptr = dlist_ptr;
    obs_msr = msr;
    chk({tag, ".done_pulse"}, line_done, 1'b0);
    chk({tag, ".dlist_ptr"}, dlist_ptr, mdl_ptr);
    chk({tag, ".msr"}, msr, mdl_msr);
    chk({tag, ".wait_vb"}, wait_vb, mdl_jvb);
    chk({tag, ".fetch_cnt"}, fetch_q.size(), ef.size());
    bad = 0;
    foreach (ef[i])
      if (i >= fetch_q.size() || fetch_q[i] !== ef[i]) bad++;
    chk({tag, ".fetch_addrs"}, bad, 0);
    bad = 0;
    foreach (ew[i])
      if (i >= wr_q.size() || wr_q[i] !== ew[i]) bad++;
    chk({tag, ".buf_writes"}, bad + wr_q.size(), ew.size());
  endtask

  task automatic pulse_vblank(input string tag);
    @(posedge phi2); #1;
    vblank = 1'b1;
    @(posedge phi2); #1;
    vblank = 1'b0;
    chk({tag, ".vb_wait_vb"}, wait_vb, 1'b0);
    chk({tag, ".vb_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [15:0] ptr;
    logic [7:0]  ir;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  pf;
    logic        en;
    logic [5:0]  bytes;
    logic [15:0] ptr_a;
    logic [15:0] msr_a;
    int          cyc;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [15:0] p1;
    int r, ld_at;
    logic en;

    vt[0] = '{16'h3C00, 8'h42, 8'h00, 8'h20, 2'b10, 1'b1,
              6'd40, 16'h3C03, 16'h2028, 86};
    vt[1] = '{16'h3C03, 8'h70, 8'h00, 8'h00, 2'b10, 1'b1,
              6'd0, 16'h3C04, 16'h2028, 2};
    vt[2] = '{16'h07FF, 8'h70, 8'h00, 8'h00, 2'b10, 1'b1,
              6'd0, 16'h0400, 16'h2028, 2};
    vt[3] = '{16'h0400, 8'h48, 8'hFF, 8'h2F, 2'b01, 1'b1,
              6'd8, 16'h0403, 16'h2007, 22};
    vt[4] = '{16'h0403, 8'h01, 8'h00, 8'h50, 2'b01, 1'b1,
              6'd0, 16'h5000, 16'h2007, 6};
    vt[5] = '{16'h5000, 8'h0F, 8'h00, 8'h00, 2'b11, 1'b1,
              6'd48, 16'h5001, 16'h2037, 98};
    vt[6] = '{16'h5001, 8'h0A, 8'h00, 8'h00, 2'b11, 1'b1,
              6'd24, 16'h5002, 16'h204F, 50};
    vt[7] = '{16'h5002, 8'h02, 8'h00, 8'h00, 2'b00, 1'b1,
              6'd0, 16'h5003, 16'h204F, 2};
    vt[8] = '{16'h5003, 8'h4F, 8'h00, 8'h00, 2'b11, 1'b0,
              6'd0, 16'h5003, 16'h204F, 0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    rst_L      = 1'b0;
    dma_en     = 1'b0;
    pf_width   = 2'b00;
    dlist_load = 1'b0;
    dlist_init = 16'h0;
    mode_req   = 1'b0;
    vblank     = 1'b0;
    repeat (3) @(posedge phi2);
    #1;
    chk("rst.halt_L", bus.halt_L, 1'b1);
    chk("rst.address", bus.address, 16'h0);
    chk("rst.dlist_ptr", dlist_ptr, 16'h0);
    chk("rst.msr", msr, 16'h0);
    chk("rst.IR", IR, 8'h0);
    chk("rst.flags", {busy, wait_vb, line_done, bus.buf_we}, 4'h0);
    chk("rst.line_bytes", line_bytes, 6'h0);
    rst_L = 1'b1;
    repeat (2) @(posedge phi2);

    foreach (vt[i]) begin
      pf_width = vt[i].pf;
      mem[vt[i].ptr] = vt[i].ir;
      p1 = wrap_next(vt[i].ptr, 10);
      mem[p1] = vt[i].lo;
      mem[wrap_next(p1, 10)] = vt[i].hi;
      run_line(vt[i].en, 0, vt[i].ptr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_bytes", i), obs_bytes, vt[i].bytes);
      chk($sformatf("vec%0d.tbl_ptr", i), obs_ptr, vt[i].ptr_a);
      chk($sformatf("vec%0d.tbl_msr", i), obs_msr, vt[i].msr_a);
      chk($sformatf("vec%0d.tbl_cyc", i), obs_cyc, vt[i].cyc);
    end

    // CPU write during the data phase wins over the sequential pointer.
    pf_width = 2'b11;
    mem[16'h5003] = 8'h0E;
    run_line(1'b1, 10, 16'h1234, "midload");
    chk("midload.ptr", obs_ptr, 16'h1234);

    // JVB: park until vblank, ignore requests meanwhile.
    mem[16'h6000] = 8'h41;
    mem[16'h6001] = 8'h00;
    mem[16'h6002] = 8'h3C;
    run_line(1'b1, 0, 16'h6000, "jvb");
    fetch_q.delete();
    mon = 1'b1;
    repeat (2) begin
      @(posedge phi2); #1;
      mode_req = 1'b1;
      @(posedge phi2); #1;
      mode_req = 1'b0;
      repeat (4) @(posedge phi2);
    end
    #1;
    mon = 1'b0;
    chk("jvb.no_dma", fetch_q.size(), 0);
    chk("jvb.still_waiting", wait_vb, 1'b1);
    chk("jvb.busy", busy, 1'b1);
    chk("jvb.one_done_pulse", ldone_cnt, 1);
    pulse_vblank("jvb");
    run_line(1'b1, -1, 16'h0, "jvb_resume");
    chk("jvb.resume_addr", fetch_q.size() > 0 ? fetch_q[0] : 16'hDEAD,
        16'h3C00);

    for (int t = 0; t < 40; t++) begin
      pf_width = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 3);
      ld_at = (r == 0) ? 0 : (r == 1 && en) ? 1 : -1;
      run_line(en, ld_at, 16'($urandom), $sformatf("rnd%0d", t));
      if (mdl_jvb) pulse_vblank($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a playfield write.
    pf_width = 2'b11;
    mem[mdl_ptr] = 8'h0F;
    @(posedge phi2); #1;
    dma_en = 1'b1;
    mode_req = 1'b1;
    @(posedge phi2); #1;
    mode_req = 1'b0;
    for (int k = 0; k < 20 && !bus.buf_we; k++) begin
      @(posedge phi2); #1;
    end
    chk("rstmid.in_cap", bus.buf_we, 1'b1);
    #2;
    rst_L = 1'b0;
    #1;
    chk("rstmid.halt_L", bus.halt_L, 1'b1);
    chk("rstmid.buf", {bus.buf_we, bus.buf_addr, bus.buf_data}, 15'h0);
    chk("rstmid.address", bus.address, 16'h0);
    chk("rstmid.ptrs", {dlist_ptr, msr}, 32'h0);
    chk("rstmid.misc", {IR, busy, wait_vb, line_done, line_bytes}, 17'h0);
    #10;
    rst_L = 1'b1;
    repeat (2) @(posedge phi2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
